// File: rtl/tick_meter_pkg.sv
// Shared definitions for the tick generator / tick period meter pair:
// FSM state encodings and default counter sizing.
package tick_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_TOUT = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_WDTH    = 30;
  localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;

endpackage

// File: rtl/tick_period_meter_if.sv
// Tick input and measurement result bundle of the tick period meter.
// The meter side uses the slave modport; the tick source / observer uses master.
interface tick_period_meter_if #(
  parameter int unsigned CNT_WDTH = tick_meter_pkg::DEF_CNT_WDTH
);
  logic                tick_in;
  logic [CNT_WDTH-1:0] period;
  logic                period_vld;
  logic                locked;
  logic                timeout;

  modport master (
    output tick_in,
    input  period,
    input  period_vld,
    input  locked,
    input  timeout
  );

  modport slave (
    input  tick_in,
    output period,
    output period_vld,
    output locked,
    output timeout
  );
endinterface

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the tick input. Define TICK_SYNC_EN to insert a
// 2-FF synchronizer in front of it (adds 2 cycles of latency).
module tick_edge_det (
  input  logic dclk,
  input  logic rst,
  input  logic tick_i,
  output logic edge_o
);

  logic tick_s;
  logic tick_q;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_q;

  // Reset to 1 so a tick already high at reset release is not taken as an edge.
  always_ff @(posedge dclk) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], tick_i};
    end
  end

  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_i;
`endif

  always_ff @(posedge dclk) begin
    if (!rst) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_s;
    end
  end

  assign edge_o = tick_s & ~tick_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures dclk cycles between rising edges of tick_in, reports lock and stall.
// Optional macro TICK_SYNC_EN adds an input synchronizer (see tick_edge_det).
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned CNT_WDTH    = DEF_CNT_WDTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned LOCK_TOL    = 0
) (
  input  logic                dclk,
  input  logic                rst,
  tick_period_meter_if.slave  bus
);

  localparam logic [CNT_WDTH-1:0] TOUT_CNT = CNT_WDTH'(TIMEOUT_CYC);
  localparam logic [CNT_WDTH:0]   TOL_W    = (CNT_WDTH + 1)'(LOCK_TOL);

  if ((TIMEOUT_CYC < 2) || (64'(TIMEOUT_CYC) > ((64'd1 << CNT_WDTH) - 64'd1))) begin : g_bad_timeout
    $error("tick_period_meter: TIMEOUT_CYC out of range for CNT_WDTH");
  end

  logic tick_edge;

  tick_edge_det u_edge_det (
    .dclk   (dclk),
    .rst    (rst),
    .tick_i (bus.tick_in),
    .edge_o (tick_edge)
  );

  state_e              state_q, state_d;
  logic [CNT_WDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WDTH-1:0] period_q, period_d;
  logic                vld_q, vld_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic                have_prev_q, have_prev_d;

  // One extra bit so the signed difference of two unsigned periods never overflows.
  logic [CNT_WDTH:0] diff;
  logic [CNT_WDTH:0] abs_diff;

  assign diff     = {1'b0, cnt_q} - {1'b0, period_q};
  assign abs_diff = diff[CNT_WDTH] ? (~diff + 1'b1) : diff;

  always_ff @(posedge dclk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      vld_q       <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      vld_q       <= vld_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    vld_d       = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (tick_edge) begin
          cnt_d   = CNT_WDTH'(1);
          state_d = ST_MEAS;
        end
      end

      // An edge on the very cycle the count reaches the limit is still a valid period.
      ST_MEAS: begin
        if (tick_edge) begin
          period_d    = cnt_q;
          vld_d       = 1'b1;
          cnt_d       = CNT_WDTH'(1);
          locked_d    = have_prev_q && (abs_diff <= TOL_W);
          have_prev_d = 1'b1;
        end else if (cnt_q == TOUT_CNT) begin
          state_d     = ST_TOUT;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_TOUT: begin
        if (tick_edge) begin
          timeout_d = 1'b0;
          cnt_d     = CNT_WDTH'(1);
          state_d   = ST_MEAS;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.period     = period_q;
  assign bus.period_vld = vld_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: two instances (lock tolerance 0 and 2) share one
// tick stream and are checked every cycle against an edge-time reference model.
module tb_tick_period_meter;

  localparam int W  = 16;
  localparam int TO = 100;
`ifdef TICK_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic dclk = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;

  always #5 dclk = ~dclk;

  tick_period_meter_if #(.CNT_WDTH(W)) bus0 ();
  tick_period_meter_if #(.CNT_WDTH(W)) bus2 ();

  assign bus0.tick_in = tick;
  assign bus2.tick_in = tick;

  tick_period_meter #(.CNT_WDTH(W), .TIMEOUT_CYC(TO), .LOCK_TOL(0)) u_dut0 (
    .dclk (dclk),
    .rst  (rst),
    .bus  (bus0)
  );

  tick_period_meter #(.CNT_WDTH(W), .TIMEOUT_CYC(TO), .LOCK_TOL(2)) u_dut2 (
    .dclk (dclk),
    .rst  (rst),
    .bus  (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remembers when the last edge happened and the last period.
  logic m_hist[$];
  logic m_prev;
  int   cyc = 0;
  bit   m_have_ref;
  int   m_ref_t;
  bit   m_have_per;
  int   m_prev_per;
  int   e_period;
  bit   e_vld;
  bit   e_lock[2];
  bit   e_to;

  // Captured by the bench on each observed vld pulse, for the table checks.
  int   vld_cnt;
  int   cap_period;
  logic cap_l0, cap_l2;

  function automatic int tol_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input logic t, input logic r);
    logic seen;
    bit   edge_now;
    int   per;
    if (!r) begin
      m_hist = {};
      for (int i = 0; i < L; i++) m_hist.push_back(1'b1);
      m_prev     = 1'b1;
      m_have_ref = 0;
      m_have_per = 0;
      m_prev_per = 0;
      e_period   = 0;
      e_vld      = 0;
      e_lock[0]  = 0;
      e_lock[1]  = 0;
      e_to       = 0;
      cyc++;
      return;
    end
    m_hist.push_back(t);
    seen     = m_hist.pop_front();
    edge_now = seen && !m_prev;
    m_prev   = seen;
    e_vld    = 0;
    if (edge_now) begin
      if (m_have_ref) begin
        per      = cyc - m_ref_t;
        e_period = per;
        e_vld    = 1;
        for (int i = 0; i < 2; i++)
          e_lock[i] = m_have_per && (iabs(per - m_prev_per) <= tol_of(i));
        m_prev_per = per;
        m_have_per = 1;
      end else begin
        e_to = 0;
      end
      m_have_ref = 1;
      m_ref_t    = cyc;
    end else if (m_have_ref && (cyc - m_ref_t == TO)) begin
      e_to       = 1;
      e_lock[0]  = 0;
      e_lock[1]  = 0;
      m_have_ref = 0;
      m_have_per = 0;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    chk("period0",  32'(bus0.period), e_period);
    chk("vld0",     32'(bus0.period_vld), 32'(e_vld));
    chk("locked0",  32'(bus0.locked), 32'(e_lock[0]));
    chk("timeout0", 32'(bus0.timeout), 32'(e_to));
    chk("period2",  32'(bus2.period), e_period);
    chk("vld2",     32'(bus2.period_vld), 32'(e_vld));
    chk("locked2",  32'(bus2.locked), 32'(e_lock[1]));
    chk("timeout2", 32'(bus2.timeout), 32'(e_to));
  endtask

  task automatic step(input logic t, input logic r);
    tick = t;
    rst  = r;
    model_step(t, r);
    @(posedge dclk);
    #1;
    check_all();
    if (bus0.period_vld === 1'b1) begin
      vld_cnt++;
      cap_period = int'(bus0.period);
      cap_l0     = bus0.locked;
      cap_l2     = bus2.locked;
    end
  endtask

  // Rising edge now, high for hi cycles, next edge gap cycles later.
  task automatic send_tick(input int gap, input int hi);
    for (int j = 0; j < gap; j++) step((j < hi) ? 1'b1 : 1'b0, 1'b1);
  endtask

  typedef struct {
    int gap;
    int hi;
    int exp_vld_n;
    int exp_period;
    bit exp_l0;
    bit exp_l2;
  } row_t;

  row_t rows[11];

  initial begin
    rows[0]  = '{10, 1, 0,  0, 0, 0};
    rows[1]  = '{10, 1, 1, 10, 0, 0};
    rows[2]  = '{10, 1, 1, 10, 1, 1};
    rows[3]  = '{20, 1, 1, 10, 1, 1};
    rows[4]  = '{20, 5, 1, 20, 0, 0};
    rows[5]  = '{12, 5, 1, 20, 1, 1};
    rows[6]  = '{10, 1, 1, 12, 0, 0};
    rows[7]  = '{12, 1, 1, 10, 0, 1};
    rows[8]  = '{10, 1, 1, 12, 0, 1};
    rows[9]  = '{10, 1, 1, 10, 0, 1};
    rows[10] = '{10, 1, 1, 10, 1, 1};

    // Reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_period", 32'(bus0.period), 0);
    chk("rst_timeout", 32'(bus0.timeout), 0);
    step(1'b0, 1'b1);

    // Table: steady ticks, wide high pulses, alternating periods vs tolerance
    for (int r = 0; r < 11; r++) begin
      vld_cnt = 0;
      send_tick(rows[r].gap, rows[r].hi);
      chk($sformatf("row%0d_vld_n", r), vld_cnt, rows[r].exp_vld_n);
      if (rows[r].exp_vld_n != 0) begin
        chk($sformatf("row%0d_period", r), cap_period, rows[r].exp_period);
        chk($sformatf("row%0d_lock0", r), 32'(cap_l0), 32'(rows[r].exp_l0));
        chk($sformatf("row%0d_lock2", r), 32'(cap_l2), 32'(rows[r].exp_l2));
      end
    end

    // Timeout exactly TO cycles after the last edge, then restart
    step(1'b1, 1'b1);
    for (int j = 1; j <= TO + L + 3; j++) begin
      step(1'b0, 1'b1);
      chk($sformatf("to_j%0d", j), 32'(bus0.timeout), (j >= TO + L) ? 1 : 0);
      if (j == TO + L - 1) chk("lock_before_to", 32'(bus0.locked), 1);
      if (j == TO + L)     chk("lock_at_to", 32'(bus0.locked), 0);
    end
    vld_cnt = 0;
    send_tick(10, 1);
    chk("restart_vld_n", vld_cnt, 0);
    chk("restart_timeout", 32'(bus0.timeout), 0);
    vld_cnt = 0;
    send_tick(10, 1);
    chk("restart2_vld_n", vld_cnt, 1);
    chk("restart2_period", cap_period, 10);
    chk("restart2_lock0", 32'(cap_l0), 0);

    // Edge on the same cycle the count reaches the limit
    send_tick(TO, 1);
    vld_cnt = 0;
    send_tick(5, 1);
    chk("edge_at_to_vld_n", vld_cnt, 1);
    chk("edge_at_to_period", cap_period, TO);
    chk("edge_at_to_timeout", 32'(bus0.timeout), 0);

    // Reset mid-measurement with tick held high across release
    send_tick(7, 1);
    step(1'b1, 1'b0);
    chk("midrst_period", 32'(bus0.period), 0);
    chk("midrst_vld", 32'(bus0.period_vld), 0);
    step(1'b1, 1'b0);
    vld_cnt = 0;
    for (int j = 0; j < 3; j++) step(1'b1, 1'b1);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1);
    send_tick(10, 1);
    chk("postrst_first_vld_n", vld_cnt, 0);
    vld_cnt = 0;
    send_tick(10, 1);
    chk("postrst_second_vld_n", vld_cnt, 1);
    chk("postrst_period", cap_period, 10);

    // Randomized stream, including gaps around the timeout limit and resets
    for (int n = 0; n < 400; n++) begin
      int gap;
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      gap = int'($urandom_range(TO - 3, TO + 3));
      else if (sel == 1) gap = int'($urandom_range(2, 4));
      else               gap = int'($urandom_range(5, 30));
      send_tick(gap, int'($urandom_range(1, gap - 1)));
      if ($urandom_range(0, 40) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b0);
        step(1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
